// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the D-stage stall controller.
package pipe_defs;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned T_W      = 2;
    localparam int unsigned MULT_CYC = 5;
    localparam int unsigned DIV_CYC  = 10;

    // Tuse encoding meaning "this source is not read".
    localparam logic [T_W-1:0] TUSE_NONE = {T_W{1'b1}};

endpackage

// File: rtl/hazard_cmp.sv
// Single source / single producer stage Tuse-Tnew hazard comparator.
module hazard_cmp #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned T_W    = 2
) (
    input  logic [REG_AW-1:0] src,
    input  logic [T_W-1:0]    tuse,
    input  logic [REG_AW-1:0] a3,
    input  logic [T_W-1:0]    tnew,
    output logic              hz
);

    // $0 and "not read" never stall; a result that arrives in time needs no stall.
    always_comb begin
        hz = (a3 != '0) && (src == a3) && (tuse != {T_W{1'b1}}) && (tnew > tuse);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// D-stage stall controller: Tuse/Tnew data hazards, MDU busy tracking, stall perf counter.
module hazard_stall_unit
    import pipe_defs::*;
#(
    parameter int unsigned REG_AW   = pipe_defs::REG_AW,
    parameter int unsigned T_W      = pipe_defs::T_W,
    parameter int unsigned MULT_CYC = pipe_defs::MULT_CYC,
    parameter int unsigned DIV_CYC  = pipe_defs::DIV_CYC,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned PERF_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_D,
    input  logic [REG_AW-1:0] rt_D,
    input  logic [T_W-1:0]    tuse_rs_D,
    input  logic [T_W-1:0]    tuse_rt_D,
    input  logic              md_D,
    input  logic [REG_AW-1:0] A3_E,
    input  logic [T_W-1:0]    tnew_E,
    input  logic [REG_AW-1:0] A3_M,
    input  logic [T_W-1:0]    tnew_M,
    input  logic              md_start_E,
    input  logic              md_div_E,
    output logic              stall,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    logic             hz_rs_e;
    logic             hz_rs_m;
    logic             hz_rt_e;
    logic             hz_rt_m;
    logic             md_hz;
    logic [CNT_W-1:0] md_cnt;

    hazard_cmp #(.REG_AW(REG_AW), .T_W(T_W)) u_cmp_rs_e (
        .src  (rs_D),
        .tuse (tuse_rs_D),
        .a3   (A3_E),
        .tnew (tnew_E),
        .hz   (hz_rs_e)
    );

    hazard_cmp #(.REG_AW(REG_AW), .T_W(T_W)) u_cmp_rs_m (
        .src  (rs_D),
        .tuse (tuse_rs_D),
        .a3   (A3_M),
        .tnew (tnew_M),
        .hz   (hz_rs_m)
    );

    hazard_cmp #(.REG_AW(REG_AW), .T_W(T_W)) u_cmp_rt_e (
        .src  (rt_D),
        .tuse (tuse_rt_D),
        .a3   (A3_E),
        .tnew (tnew_E),
        .hz   (hz_rt_e)
    );

    hazard_cmp #(.REG_AW(REG_AW), .T_W(T_W)) u_cmp_rt_m (
        .src  (rt_D),
        .tuse (tuse_rt_D),
        .a3   (A3_M),
        .tnew (tnew_M),
        .hz   (hz_rt_m)
    );

    // MDU is busy from the start cycle until the latency counter drains.
    always_comb begin
        md_busy = md_start_E || (md_cnt != '0);
        md_hz   = md_D && md_busy;
        stall   = hz_rs_e || hz_rs_m || hz_rt_e || hz_rt_m || md_hz;
    end

    // MDU latency counter: load on start (restart reloads), else count down to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (md_start_E) begin
            md_cnt <= md_div_E ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {PERF_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; a second instance with a 4-bit perf counter
// checks saturation.
module tb_hazard_stall_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_D;
    logic [4:0]  rt_D;
    logic [1:0]  tuse_rs_D;
    logic [1:0]  tuse_rt_D;
    logic        md_D;
    logic [4:0]  A3_E;
    logic [1:0]  tnew_E;
    logic [4:0]  A3_M;
    logic [1:0]  tnew_M;
    logic        md_start_E;
    logic        md_div_E;
    logic        stall;
    logic        md_busy;
    logic [31:0] stall_cnt;
    logic        stall4;
    logic        md_busy4;
    logic [3:0]  stall_cnt4;

    int n_checks;
    int n_fails;

    hazard_stall_unit dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .md_D       (md_D),
        .A3_E       (A3_E),
        .tnew_E     (tnew_E),
        .A3_M       (A3_M),
        .tnew_M     (tnew_M),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .stall      (stall),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    hazard_stall_unit #(.PERF_W(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .md_D       (md_D),
        .A3_E       (A3_E),
        .tnew_E     (tnew_E),
        .A3_M       (A3_M),
        .tnew_M     (tnew_M),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .stall      (stall4),
        .md_busy    (md_busy4),
        .stall_cnt  (stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_D       = '0;
        rt_D       = '0;
        tuse_rs_D  = 2'b11;
        tuse_rt_D  = 2'b11;
        md_D       = 1'b0;
        A3_E       = '0;
        tnew_E     = '0;
        A3_M       = '0;
        tnew_M     = '0;
        md_start_E = 1'b0;
        md_div_E   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check_eq("reset_stall", 32'(stall), 32'd0);
        check_eq("reset_busy", 32'(md_busy), 32'd0);
        check_eq("reset_cnt", stall_cnt, 32'd0);

        // lw in E feeding addu in D, then the same producer one stage later
        rs_D = 5'd8; tuse_rs_D = 2'd1; A3_E = 5'd8; tnew_E = 2'd2;
        #1;
        check_eq("lw_E_stall", 32'(stall), 32'd1);
        step();
        A3_E = '0; tnew_E = '0; A3_M = 5'd8; tnew_M = 2'd1;
        #1;
        check_eq("lw_M_nostall", 32'(stall), 32'd0);
        check_eq("cnt_after_lw", stall_cnt, 32'd1);

        // beq needs rs immediately, addu in E not yet forwardable
        idle_inputs();
        rs_D = 5'd9; tuse_rs_D = 2'd0; A3_E = 5'd9; tnew_E = 2'd1;
        #1;
        check_eq("beq_E_stall", 32'(stall), 32'd1);
        step();
        A3_E = '0;
        #1;
        check_eq("beq_bubble_nostall", 32'(stall), 32'd0);

        // rt path against M stage
        idle_inputs();
        rt_D = 5'd9; tuse_rt_D = 2'd0; A3_M = 5'd9; tnew_M = 2'd1;
        #1;
        check_eq("rt_M_stall", 32'(stall), 32'd1);
        step();

        // $0, unread source, tnew 0 and tnew == tuse never stall
        idle_inputs();
        tuse_rs_D = 2'd0; tuse_rt_D = 2'd0; tnew_E = 2'd2;
        #1;
        check_eq("zero_reg_nostall", 32'(stall), 32'd0);
        rs_D = 5'd5; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; A3_E = 5'd5;
        #1;
        check_eq("tuse_none_nostall", 32'(stall), 32'd0);
        tuse_rs_D = 2'd0; tnew_E = 2'd0;
        #1;
        check_eq("tnew0_nostall", 32'(stall), 32'd0);
        tuse_rs_D = 2'd1; tnew_E = 2'd1;
        #1;
        check_eq("tnew_eq_tuse_nostall", 32'(stall), 32'd0);
        idle_inputs();
        step();
        check_eq("cnt_after_data", stall_cnt, 32'd3);

        // div followed by mflo: stalled for the start cycle plus DIV_CYC cycles
        md_D = 1'b1; md_start_E = 1'b1; md_div_E = 1'b1;
        #1;
        check_eq("div_start_stall", 32'(stall), 32'd1);
        check_eq("div_start_busy", 32'(md_busy), 32'd1);
        step();
        md_start_E = 1'b0; md_div_E = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            check_eq($sformatf("div_busy_%0d", i), 32'(stall), 32'd1);
            step();
        end
        check_eq("div_release", 32'(stall), 32'd0);
        check_eq("div_busy_clear", 32'(md_busy), 32'd0);
        check_eq("cnt_after_div", stall_cnt, 32'd14);

        // mult: start cycle plus MULT_CYC cycles
        md_start_E = 1'b1;
        #1;
        check_eq("mult_start_stall", 32'(stall), 32'd1);
        step();
        md_start_E = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check_eq($sformatf("mult_busy_%0d", i), 32'(stall), 32'd1);
            step();
        end
        check_eq("mult_release", 32'(stall), 32'd0);
        check_eq("cnt_after_mult", stall_cnt, 32'd20);

        // reset three cycles into a div
        idle_inputs();
        md_start_E = 1'b1; md_div_E = 1'b1;
        step();
        md_start_E = 1'b0; md_div_E = 1'b0;
        step();
        step();
        reset = 1'b1; md_D = 1'b1;
        #1;
        check_eq("reset_comb_stall", 32'(stall), 32'd1);
        step();
        reset = 1'b0;
        #1;
        check_eq("rst_mid_busy", 32'(md_busy), 32'd0);
        check_eq("rst_mid_cnt", stall_cnt, 32'd0);
        check_eq("rst_mid_mflo", 32'(stall), 32'd0);

        // held hazard: 32-bit counter keeps counting, 4-bit counter saturates
        idle_inputs();
        rs_D = 5'd8; tuse_rs_D = 2'd1; A3_E = 5'd8; tnew_E = 2'd2;
        for (int i = 0; i < 14; i++) step();
        check_eq("sat_cnt4_14", 32'(stall_cnt4), 32'd14);
        for (int i = 0; i < 6; i++) step();
        check_eq("sat_cnt4_20", 32'(stall_cnt4), 32'd15);
        check_eq("cnt32_20", stall_cnt, 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
